mrr_decoded_stream_arbiter: RTL and testbench

MRR_DECODED_STREAM_ARBITER -- requirements
Module: mrr_decoded_stream_arbiter

---
 rtl/mrr_decoded_stream_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mrr_decoded_stream_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrr_decoded_stream_arbiter.sv
// mrr_decoded_stream_arbiter: packet-granular round-robin merge of per-pathway
// decoded 32-bit word streams into a single AXI-stream. A granted pathway owns
// the output until its tlast beat. If the pathway stalls too long, the packet is
// terminated with a marker word.
module mrr_decoded_stream_arbiter #(
  parameter int NUM_PATHWAYS      = 4,
  parameter int PATHWAY_IDX_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [32*NUM_PATHWAYS-1:0]   i_tdata,
  input  logic [NUM_PATHWAYS-1:0]      i_tvalid,
  input  logic [NUM_PATHWAYS-1:0]      i_tlast,
  output logic [NUM_PATHWAYS-1:0]      i_tready,
  output logic [31:0]                  o_tdata,
  output logic                         o_tlast,
  output logic                         o_tvalid,
  output logic [PATHWAY_IDX_WIDTH-1:0] o_tuser,
  input  logic                         o_tready,
  input  logic [15:0]                  timeout_len,
  output logic [15:0]                  abort_count,
  output logic                         busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS  = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  localparam int unsigned NP = NUM_PATHWAYS;

  state_t                       r_state;
  logic [PATHWAY_IDX_WIDTH-1:0] r_grant;
  logic [PATHWAY_IDX_WIDTH-1:0] r_last_grant;
  logic [15:0]                  r_stall;
  logic [15:0]                  r_abort_count;
  logic [31:0]                  r_tdata;
  logic                         r_tlast;
  logic                         r_tvalid;
  logic [PATHWAY_IDX_WIDTH-1:0] r_tuser;

  logic [31:0]                  w_word [NUM_PATHWAYS];
  logic                         w_found;
  logic [PATHWAY_IDX_WIDTH-1:0] w_pick;
  int unsigned                  w_idx;
  logic [NUM_PATHWAYS-1:0]      w_sel;
  logic                         w_out_free;
  logic                         w_g_valid;
  logic                         w_g_last;
  logic [31:0]                  w_g_data;
  logic                         w_accept;
  logic                         w_timeout;

  // Split the flat input data bus into per-pathway words
  always_comb begin
    for (int unsigned p = 0; p < NP; p++) begin
      w_word[p] = i_tdata[32*p +: 32];
    end
  end

  // Circular search for the first valid pathway after the last granted one
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    w_sel   = '0;
    for (int unsigned k = 1; k <= NP; k++) begin
      w_idx = (32'(r_last_grant) + k) % NP;
      w_sel = NUM_PATHWAYS'(1) << w_idx;
      if (!w_found && |(i_tvalid & w_sel)) begin
        w_found = 1'b1;
        w_pick  = w_idx[PATHWAY_IDX_WIDTH-1:0];
      end
    end
  end

  assign w_out_free = !r_tvalid || o_tready;
  assign w_g_valid  = i_tvalid[r_grant];
  assign w_g_last   = i_tlast[r_grant];
  assign w_g_data   = w_word[r_grant];
  assign w_accept   = (r_state == S_PASS) && w_g_valid && w_out_free;
  // >= rather than == so that lowering timeout_len below the current count
  // still aborts on the next cycle.
  assign w_timeout  = (timeout_len != '0) && (r_stall >= timeout_len);

  // Ready only to the granted pathway while the output register can take a beat;
  // held low during reset so that no upstream beat is consumed and lost.
  always_comb begin
    i_tready = '0;
    if ((r_state == S_PASS) && w_out_free && !rst) begin
      i_tready[r_grant] = 1'b1;
    end
  end

  // Arbitration FSM, stall timer, abort counter and single-entry output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_last_grant  <= PATHWAY_IDX_WIDTH'(NUM_PATHWAYS - 1);
      r_stall       <= '0;
      r_abort_count <= '0;
      r_tdata       <= '0;
      r_tlast       <= 1'b0;
      r_tvalid      <= 1'b0;
      r_tuser       <= '0;
    end else begin
      // Drain first; a load in the same cycle below overrides this, giving
      // back-to-back beats without a bubble.
      if (r_tvalid && o_tready) begin
        r_tvalid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_stall <= '0;
            r_state <= S_PASS;
          end
        end
        S_PASS: begin
          if (w_accept) begin
            r_tdata  <= w_g_data;
            r_tlast  <= w_g_last;
            r_tuser  <= r_grant;
            r_tvalid <= 1'b1;
            r_stall  <= '0;
            if (w_g_last) begin
              r_last_grant <= r_grant;
              r_state      <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_state <= S_ABORT;
          end else if ((timeout_len != '0) && !w_g_valid) begin
            r_stall <= r_stall + 16'd1;
          end
        end
        S_ABORT: begin
          if (w_out_free) begin
            r_tdata  <= 32'hDEAD0000 | 32'(r_grant);
            r_tlast  <= 1'b1;
            r_tuser  <= r_grant;
            r_tvalid <= 1'b1;
            if (r_abort_count != '1) begin
              r_abort_count <= r_abort_count + 16'd1;
            end
            r_last_grant <= r_grant;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tdata     = r_tdata;
  assign o_tlast     = r_tlast;
  assign o_tvalid    = r_tvalid;
  assign o_tuser     = r_tuser;
  assign abort_count = r_abort_count;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mrr_decoded_stream_arbiter.sv
// Self-checking bench for mrr_decoded_stream_arbiter: per-pathway source queues
// feed the DUT, expected output beats are queued by each scenario and compared
// as the DUT delivers them.
module tb_mrr_decoded_stream_arbiter;

  localparam int NP = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [32*NP-1:0] i_tdata;
  logic [NP-1:0]    i_tvalid;
  logic [NP-1:0]    i_tlast;
  logic [NP-1:0]    i_tready;
  logic [31:0]      o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic [IW-1:0]    o_tuser;
  logic             o_tready;
  logic [15:0]      timeout_len;
  logic [15:0]      abort_count;
  logic             busy;

  mrr_decoded_stream_arbiter #(
    .NUM_PATHWAYS      (NP),
    .PATHWAY_IDX_WIDTH (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_tdata     (i_tdata),
    .i_tvalid    (i_tvalid),
    .i_tlast     (i_tlast),
    .i_tready    (i_tready),
    .o_tdata     (o_tdata),
    .o_tlast     (o_tlast),
    .o_tvalid    (o_tvalid),
    .o_tuser     (o_tuser),
    .o_tready    (o_tready),
    .timeout_len (timeout_len),
    .abort_count (abort_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  user;
  } exp_t;

  typedef struct {
    logic [3:0] mask;
    logic [1:0] exp_first;
    int         exp_count;
  } vec_t;

  beat_t       srcq [NP][$];
  exp_t        exp_q[$];
  int          fire_cyc[$];
  int          last_fire_cyc[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          tready_toggle = 1'b0;
  bit          prev_stall = 1'b0;
  bit          skip_stab = 1'b0;
  logic [31:0] held_data;
  logic        held_last;
  logic [1:0]  held_user;
  logic [1:0]  first_user;
  int          dead_cyc;
  logic        dead_busy;
  logic [15:0] dead_cnt;
  vec_t        tbl[6];

  function automatic logic [31:0] wd(input int p, input int tag, input int b);
    return {4'hA, 4'(p), 8'(tag), 16'(b)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (srcq[p].size() != 0) begin
        i_tvalid[p]          = 1'b1;
        i_tdata[32*p +: 32]  = srcq[p][0].data;
        i_tlast[p]           = srcq[p][0].last;
      end else begin
        i_tvalid[p]          = 1'b0;
        i_tdata[32*p +: 32]  = '0;
        i_tlast[p]           = 1'b0;
      end
    end
  endtask

  // One clock cycle: monitor/compare at the falling edge, then advance sources.
  task automatic step();
    logic [NP-1:0] acc;
    exp_t          e;
    #4;
    if (prev_stall && !skip_stab) begin
      chk("hold_valid", 32'(o_tvalid), 32'd1);
      chk("hold_data", o_tdata, held_data);
      chk("hold_last_user", {o_tlast, o_tuser}, {held_last, held_user});
    end
    skip_stab  = 1'b0;
    prev_stall = o_tvalid && !o_tready;
    held_data  = o_tdata;
    held_last  = o_tlast;
    held_user  = o_tuser;
    if (o_tvalid && o_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out: got %h required no output (cycle %0d)", o_tdata, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", o_tdata, e.data);
        chk("out_last", 32'(o_tlast), 32'(e.last));
        chk("out_user", 32'(o_tuser), 32'(e.user));
      end
      if (fire_cyc.size() == 0) first_user = o_tuser;
      fire_cyc.push_back(cyc);
      if (o_tlast) last_fire_cyc.push_back(cyc);
      if (o_tdata[31:16] == 16'hDEAD) begin
        dead_cyc  = cyc;
        dead_busy = busy;
        dead_cnt  = abort_count;
      end
    end
    acc = i_tvalid & i_tready;
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) void'(srcq[p].pop_front());
    end
    if (tready_toggle) o_tready = ~o_tready;
    drive();
  endtask

  task automatic clear_logs();
    fire_cyc.delete();
    last_fire_cyc.delete();
    dead_cyc   = -1;
    first_user = '0;
  endtask

  task automatic clear_all();
    for (int p = 0; p < NP; p++) srcq[p].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    o_tready = 1'b0;
    tready_toggle = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    skip_stab  = 1'b1;
    prev_stall = 1'b0;
    clear_logs();
    drive();
  endtask

  task automatic add_pkt(input int p, input int n, input int tag);
    for (int b = 0; b < n; b++) srcq[p].push_back('{data: wd(p, tag, b), last: (b == n - 1)});
  endtask

  task automatic exp_pkt(input int p, input int n, input int tag);
    for (int b = 0; b < n; b++)
      exp_q.push_back('{data: wd(p, tag, b), last: (b == n - 1), user: 2'(p)});
  endtask

  task automatic run_drain(input int budget, input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout with %0d outputs outstanding, required 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (3) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b0110, 2'd1, 2};
    tbl[1] = '{4'b1000, 2'd3, 1};
    tbl[2] = '{4'b1111, 2'd0, 4};
    tbl[3] = '{4'b1100, 2'd2, 2};
    tbl[4] = '{4'b0001, 2'd0, 1};
    tbl[5] = '{4'b1010, 2'd1, 2};

    rst = 1'b1;
    o_tready = 1'b0;
    timeout_len = '0;
    i_tvalid = '0;
    i_tlast = '0;
    i_tdata = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    chk("rst_tvalid", 32'(o_tvalid), 32'd0);
    chk("rst_tlast", 32'(o_tlast), 32'd0);
    chk("rst_tdata", o_tdata, 32'd0);
    chk("rst_tuser", 32'(o_tuser), 32'd0);
    chk("rst_abort_count", 32'(abort_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tready", 32'(i_tready), 32'd0);

    // Table: single-beat packets presented together right after reset
    for (int i = 0; i < 6; i++) begin
      clear_all();
      do_reset();
      o_tready = 1'b1;
      for (int p = 0; p < NP; p++) begin
        if (tbl[i].mask[p]) begin
          add_pkt(p, 1, i);
          exp_pkt(p, 1, i);
        end
      end
      drive();
      run_drain(40, "tbl_drain");
      chk("tbl_first_user", 32'(first_user), 32'(tbl[i].exp_first));
      chk("tbl_count", fire_cyc.size(), tbl[i].exp_count);
    end

    // Two 3-beat packets on pathways 1 and 2, one bubble between them
    clear_all();
    do_reset();
    o_tready = 1'b1;
    add_pkt(1, 3, 1);
    add_pkt(2, 3, 2);
    exp_pkt(1, 3, 1);
    exp_pkt(2, 3, 2);
    drive();
    run_drain(40, "two_pkt_drain");
    chk("two_pkt_count", fire_cyc.size(), 6);
    if (fire_cyc.size() == 6) begin
      chk("two_pkt_gap_b0b1", fire_cyc[1] - fire_cyc[0], 1);
      chk("two_pkt_gap_b1b2", fire_cyc[2] - fire_cyc[1], 1);
      chk("two_pkt_bubble", fire_cyc[3] - fire_cyc[2], 2);
      chk("two_pkt_gap_p2", fire_cyc[5] - fire_cyc[3], 2);
    end

    // All pathways continuously valid with 2-beat packets: order 0,1,2,3,0
    clear_all();
    do_reset();
    o_tready = 1'b1;
    add_pkt(0, 2, 1);
    add_pkt(1, 2, 2);
    add_pkt(2, 2, 3);
    add_pkt(3, 2, 4);
    add_pkt(0, 2, 5);
    exp_pkt(0, 2, 1);
    exp_pkt(1, 2, 2);
    exp_pkt(2, 2, 3);
    exp_pkt(3, 2, 4);
    exp_pkt(0, 2, 5);
    drive();
    run_drain(60, "rr_drain");
    chk("rr_pkt_count", last_fire_cyc.size(), 5);
    if (last_fire_cyc.size() == 5) begin
      for (int k = 0; k < 4; k++) chk("rr_pkt_period", last_fire_cyc[k+1] - last_fire_cyc[k], 3);
    end

    // Output backpressure toggling during a 4-beat packet
    clear_all();
    do_reset();
    timeout_len = 16'd2;
    o_tready = 1'b1;
    tready_toggle = 1'b1;
    add_pkt(0, 4, 7);
    exp_pkt(0, 4, 7);
    drive();
    run_drain(60, "toggle_drain");
    tready_toggle = 1'b0;
    o_tready = 1'b1;
    chk("toggle_count", fire_cyc.size(), 4);
    chk("toggle_abort_count", 32'(abort_count), 32'd0);

    // Timeout abort: pathway 3 sends one beat then goes quiet
    clear_all();
    do_reset();
    timeout_len = 16'd5;
    o_tready = 1'b1;
    srcq[3].push_back('{data: wd(3, 9, 0), last: 1'b0});
    exp_q.push_back('{data: wd(3, 9, 0), last: 1'b0, user: 2'd3});
    exp_q.push_back('{data: 32'hDEAD0003, last: 1'b1, user: 2'd3});
    drive();
    run_drain(40, "abort_drain");
    chk("abort_seen", 32'(dead_cyc >= 0), 32'd1);
    if (dead_cyc >= 0 && fire_cyc.size() != 0) begin
      chk("abort_latency", dead_cyc - fire_cyc[0], 7);
      chk("abort_busy", 32'(dead_busy), 32'd0);
      chk("abort_cnt", 32'(dead_cnt), 32'd1);
    end
    // Rest of the aborted packet is forwarded as a fresh packet later
    srcq[3].push_back('{data: wd(3, 9, 1), last: 1'b1});
    exp_q.push_back('{data: wd(3, 9, 1), last: 1'b1, user: 2'd3});
    drive();
    run_drain(40, "abort_tail_drain");
    chk("abort_tail_cnt", 32'(abort_count), 32'd1);

    // Lowering timeout_len below the running stall count mid-packet
    clear_all();
    do_reset();
    timeout_len = 16'd100;
    o_tready = 1'b1;
    srcq[0].push_back('{data: wd(0, 11, 0), last: 1'b0});
    exp_q.push_back('{data: wd(0, 11, 0), last: 1'b0, user: 2'd0});
    exp_q.push_back('{data: 32'hDEAD0000, last: 1'b1, user: 2'd0});
    drive();
    repeat (4) step();
    timeout_len = 16'd1;
    run_drain(20, "tlen_change_drain");
    chk("tlen_change_cnt", 32'(abort_count), 32'd1);

    // Reset mid-packet: output register discarded, upstream beats kept
    clear_all();
    clear_logs();
    timeout_len = '0;
    o_tready = 1'b1;
    add_pkt(1, 4, 3);
    exp_q.push_back('{data: wd(1, 3, 0), last: 1'b0, user: 2'd1});
    drive();
    repeat (3) step();
    chk("midrst_pre_outstanding", exp_q.size(), 0);
    add_pkt(0, 1, 4);
    do_reset();
    chk("midrst_tvalid", 32'(o_tvalid), 32'd0);
    chk("midrst_tready", 32'(i_tready), 32'd0);
    chk("midrst_abort_count", 32'(abort_count), 32'd0);
    chk("midrst_pending", srcq[1].size(), 2);
    o_tready = 1'b1;
    exp_pkt(0, 1, 4);
    for (int k = 0; k < srcq[1].size(); k++)
      exp_q.push_back('{data: srcq[1][k].data, last: srcq[1][k].last, user: 2'd1});
    drive();
    run_drain(40, "midrst_drain");
    chk("midrst_first_user", 32'(first_user), 32'd0);

    // Saturation of abort_count
    clear_all();
    do_reset();
    timeout_len = 16'd1;
    o_tready = 1'b1;
    force dut.r_abort_count = 16'hFFFE;
    step();
    release dut.r_abort_count;
    for (int a = 0; a < 2; a++) begin
      srcq[2].push_back('{data: wd(2, 20 + a, 0), last: 1'b0});
      exp_q.push_back('{data: wd(2, 20 + a, 0), last: 1'b0, user: 2'd2});
      exp_q.push_back('{data: 32'hDEAD0002, last: 1'b1, user: 2'd2});
      drive();
      run_drain(30, "sat_drain");
      chk("sat_abort_count", 32'(abort_count), 32'h0000FFFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
